spi_bit_counter: RTL and testbench

SPI_BIT_COUNTER -- requirements
Module: spi_bit_counter

---
 rtl/spi_bit_counter.sv | 119 +++++++++++
 tb/tb_spi_bit_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bit_counter.sv
// SPI frame bit counter: tracks the index of the next sampled bit and
// flags the sample edge and frame completion for a shift register.
module spi_bit_counter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             lsbfe,
  input  logic [CNT_W-1:0] len_m1,
  input  logic             sck_rise,
  input  logic             sck_fall,
  output logic [CNT_W-1:0] bit_idx,
  output logic             sample_stb,
  output logic             busy,
  output logic             done
);

  if (DATA_W < 2 || DATA_W > 64 || (DATA_W & (DATA_W - 1)) != 0)
  begin : g_bad_data_w
    $error("DATA_W must be a power of two in 2..64");
  end

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             lsbfe_q, lsbfe_d;
  logic             done_q, done_d;

  logic             samp_edge;
  logic [CNT_W-1:0] end_idx;
  logic             is_last;

  // Modes 1 and 2 sample on the falling SCK edge, modes 0 and 3 on rising.
  always_comb begin
    samp_edge = (cpol_q ^ cpha_q) ? sck_fall : sck_rise;
    end_idx   = lsbfe_q ? len_q : '0;
    is_last   = (idx_q == end_idx);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsbfe_d = lsbfe_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_ACTIVE;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsbfe_d = lsbfe;
          len_d   = len_m1;
          idx_d   = lsbfe ? '0 : len_m1;
        end
      end
      S_ACTIVE: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (samp_edge) begin
          if (is_last) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else if (lsbfe_q) begin
            idx_d = idx_q + CNT_W'(1);
          end else begin
            idx_d = idx_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsbfe_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsbfe_q <= lsbfe_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == S_ACTIVE);
  assign sample_stb = busy & samp_edge;
  assign bit_idx    = idx_q;
  assign done       = done_q;

endmodule

// File: tb/tb_spi_bit_counter.sv
// Bench for spi_bit_counter: directed frames plus random traffic,
// checked against a queue-of-indices frame model via a scoreboard.
module tb_spi_bit_counter;
  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic          lsbfe = 1'b0;
  logic [CW-1:0] len_m1 = '0;
  logic          sck_rise = 1'b0;
  logic          sck_fall = 1'b0;
  logic [CW-1:0] bit_idx;
  logic          sample_stb;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  spi_bit_counter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe), .len_m1(len_m1),
    .sck_rise(sck_rise), .sck_fall(sck_fall),
    .bit_idx(bit_idx), .sample_stb(sample_stb),
    .busy(busy), .done(done)
  );

  typedef struct {
    bit is_done;
    int idx;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;

  // frame model: remaining bit indices of the current frame, in order
  bit  m_active = 0;
  bit  m_done_now = 0;
  bit  m_fall = 0;
  int  m_rem[$];

  bit  exp_busy = 0;
  bit  exp_done = 0;
  int  exp_idx = 0;
  bit  chk_en = 0;

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // monitor: compares outputs and pops scoreboard events
  always @(negedge clk) begin
    ev_t ev;
    if (chk_en && rst) begin
      check("busy", int'(busy), int'(exp_busy));
      check("bit_idx", int'(bit_idx), exp_idx);
      check("done", int'(done), int'(exp_done));
      if (sample_stb) begin
        if (sb.size() == 0 || sb[0].is_done) begin
          total++; bad++;
          $display("FAIL sample_unexpected actual=1 required=0 idx=%0d", bit_idx);
        end else begin
          ev = sb.pop_front();
          check("sample_idx", int'(bit_idx), ev.idx);
        end
      end
      if (done) begin
        if (sb.size() == 0 || !sb[0].is_done) begin
          total++; bad++;
          $display("FAIL done_unexpected actual=1 required=0");
        end else begin
          ev = sb.pop_front();
          total++;
        end
      end
      check("missing_events", sb.size(), 0);
      sb.delete();
    end
  end

  task automatic drive(bit st, bit ab, bit pol, bit pha, bit lsb,
                       int len, bit r, bit f);
    ev_t ev;
    bit  hit;
    @(posedge clk);
    #1;
    start = st; abort = ab; cpol = pol; cpha = pha;
    lsbfe = lsb; len_m1 = len[CW-1:0];
    sck_rise = r; sck_fall = f;
    exp_busy = m_active;
    exp_idx  = m_active ? m_rem[0] : 0;
    exp_done = m_done_now;
    hit = m_active && (m_fall ? f : r);
    if (m_done_now) begin
      ev.is_done = 1; ev.idx = 0;
      sb.push_back(ev);
    end
    if (hit) begin
      ev.is_done = 0; ev.idx = m_rem[0];
      sb.push_back(ev);
    end
    m_done_now = 0;
    if (m_active) begin
      if (ab) begin
        m_active = 0;
        m_rem.delete();
      end else if (hit) begin
        void'(m_rem.pop_front());
        if (m_rem.size() == 0) begin
          m_active = 0;
          m_done_now = 1;
        end
      end
    end else if (st && !ab) begin
      m_active = 1;
      m_fall = pol ^ pha;
      m_rem.delete();
      for (int i = 0; i <= len; i++)
        m_rem.push_back(lsb ? i : len - i);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    start = 0; abort = 0; sck_rise = 0; sck_fall = 0;
    rst = 0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_idx", int'(bit_idx), 0);
    check("rst_done", int'(done), 0);
    m_active = 0; m_done_now = 0; m_rem.delete();
    exp_busy = 0; exp_idx = 0; exp_done = 0;
    #1;
    rst = 1;
  endtask

  initial begin
    #2;
    check("por_busy", int'(busy), 0);
    check("por_idx", int'(bit_idx), 0);
    check("por_done", int'(done), 0);
    check("por_stb", int'(sample_stb), 0);
    #20;
    @(negedge clk);
    rst = 1;
    chk_en = 1;
    idle(2);

    // mode 0, LSB first, 8 bits on rising strobes
    drive(1, 0, 0, 0, 1, 7, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 1, 7, 1, 0);
      drive(0, 0, 0, 0, 1, 7, 0, 0);
    end
    idle(2);

    // mode 1, MSB first, alternating strobes: only falls count
    drive(1, 0, 0, 1, 0, 7, 0, 0);
    for (int i = 0; i < 18; i++)
      drive(0, 0, 0, 1, 0, 7, (i % 2) == 0, (i % 2) == 1);
    idle(2);

    // mode 2, single-bit frame
    drive(1, 0, 1, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 1, 0, 1, 1);
    idle(2);

    // abort coincident with a sample edge at bit 3
    drive(1, 0, 0, 0, 1, 7, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 7, 1, 0);
    drive(0, 1, 0, 0, 1, 7, 1, 0);
    idle(2);

    // abort with start in idle; abort on the last edge
    drive(1, 1, 0, 0, 1, 3, 0, 0);
    idle(1);
    drive(1, 0, 1, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 9, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 0);
    idle(2);

    // reset mid-frame at bit 5, then clean 4-bit frame
    drive(1, 0, 0, 0, 1, 7, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 7, 1, 0);
    pulse_reset();
    idle(1);
    drive(1, 0, 0, 0, 1, 3, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 3, 1, 0);

    // back-to-back: start in the done cycle, 16-bit MSB-first frame
    drive(1, 0, 0, 0, 0, 15, 0, 0);
    for (int i = 0; i < 16; i++) drive(1, 0, 1, 1, 1, 2, 1, 0);
    idle(3);

    // random traffic with mode/length noise while active
    for (int i = 0; i < 3000; i++)
      drive(($urandom % 6) == 0, ($urandom % 40) == 0,
            1'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, DW - 1)),
            ($urandom % 3) != 0, ($urandom % 3) != 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);

    @(posedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
